// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO slice.
package uart_rx_fifo_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uartByte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side capture signals and consumer-side FWFT read handshake.
interface uart_rx_fifo_if;
    import uart_rx_fifo_pkg::*;

    logic      rxDone;
    logic      rxErr;
    uartByte_t rxByte;
    logic      rdEn;
    uartByte_t dataOut;
    logic      dataValid;

    modport master (
        output rxDone,
        output rxErr,
        output rxByte,
        output rdEn,
        input  dataOut,
        input  dataValid
    );

    modport slave (
        input  rxDone,
        input  rxErr,
        input  rxByte,
        input  rdEn,
        output dataOut,
        output dataValid
    );

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module uart_rx_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: rxDone edge capture, error/overflow
// accounting and first-word-fall-through read.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned KEEP_ERR_BYTES = 0,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_rx_fifo_if.slave            rxIf,
    input  logic                     clearFlags,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         errCount,
    output logic [CNT_W-1:0]         ovfCount
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wrPtr;
    logic [AW:0]  rdPtr;
    logic         doneQ;
    logic         capture;
    logic         wrReq;
    logic         empty;
    logic         isFull;
    logic         pop;
    logic         wrEn;
    logic         ovfEvt;
    logic         errEvt;
    uartByte_t    memRd;

    // An event coinciding with clearFlags leaves the counter at one.
    function automatic logic [CNT_W-1:0] nextCnt(
        input logic [CNT_W-1:0] cur,
        input logic             evt,
        input logic             clr
    );
        logic [CNT_W-1:0] res;
        res = cur;
        if (evt && clr) begin
            res = CNT_W'(1);
        end else if (clr) begin
            res = '0;
        end else if (evt && (cur != '1)) begin
            res = cur + CNT_W'(1);
        end
        return res;
    endfunction

    // Capture, write-accept and flag-event decode.
    always_comb begin
        capture = rxIf.rxDone & ~doneQ;
        wrReq   = capture & (~rxIf.rxErr | (KEEP_ERR_BYTES != 0));
        empty   = (wrPtr == rdPtr);
        isFull  = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) & (wrPtr[AW] != rdPtr[AW]);
        pop     = rxIf.rdEn & ~empty;
        // A pop on a full FIFO frees the slot the incoming byte lands in.
        wrEn    = wrReq & (~isFull | pop);
        ovfEvt  = wrReq & isFull & ~pop;
        errEvt  = capture & rxIf.rxErr;
    end

    // Pointers, edge-detect register, sticky flag and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            doneQ    <= 1'b0;
            overflow <= 1'b0;
            errCount <= '0;
            ovfCount <= '0;
        end else begin
            doneQ <= rxIf.rxDone;
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (ovfEvt) begin
                overflow <= 1'b1;
            end else if (clearFlags) begin
                overflow <= 1'b0;
            end
            errCount <= nextCnt(errCount, errEvt, clearFlags);
            ovfCount <= nextCnt(ovfCount, ovfEvt, clearFlags);
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) uMem (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (wrPtr[AW-1:0]),
        .wrData (rxIf.rxByte),
        .rdAddr (rdPtr[AW-1:0]),
        .rdData (memRd)
    );

    assign full           = isFull;
    assign count          = wrPtr - rdPtr;
    assign rxIf.dataValid = ~empty;
    assign rxIf.dataOut   = empty ? '0 : memRd;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one instance drops error bytes, one keeps
// them; both are compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxByte;
    logic       rdEn;
    logic       clearFlags;

    logic       full   [2];
    logic [4:0] cnt    [2];
    logic       ovf    [2];
    logic [7:0] errC   [2];
    logic [7:0] ovfC   [2];
    logic [7:0] dOut   [2];
    logic       dValid [2];

    int checks = 0;
    int errors = 0;

    uart_rx_fifo_if bus0 ();
    uart_rx_fifo_if bus1 ();

    assign bus0.rxDone = rxDone;
    assign bus0.rxErr  = rxErr;
    assign bus0.rxByte = rxByte;
    assign bus0.rdEn   = rdEn;
    assign bus1.rxDone = rxDone;
    assign bus1.rxErr  = rxErr;
    assign bus1.rxByte = rxByte;
    assign bus1.rdEn   = rdEn;
    assign dOut[0]     = bus0.dataOut;
    assign dValid[0]   = bus0.dataValid;
    assign dOut[1]     = bus1.dataOut;
    assign dValid[1]   = bus1.dataValid;

    uart_rx_fifo #(.DEPTH(DEPTH), .KEEP_ERR_BYTES(0), .CNT_W(8)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .rxIf       (bus0),
        .clearFlags (clearFlags),
        .full       (full[0]),
        .count      (cnt[0]),
        .overflow   (ovf[0]),
        .errCount   (errC[0]),
        .ovfCount   (ovfC[0])
    );

    uart_rx_fifo #(.DEPTH(DEPTH), .KEEP_ERR_BYTES(1), .CNT_W(8)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .rxIf       (bus1),
        .clearFlags (clearFlags),
        .full       (full[1]),
        .count      (cnt[1]),
        .overflow   (ovf[1]),
        .errCount   (errC[1]),
        .ovfCount   (ovfC[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Reference model: a byte queue plus flag/counter values per instance.
    logic [7:0] mq [2][$];
    bit         mOvf   [2];
    int         mErr   [2];
    int         mOvfC  [2];
    bit         prevDone = 1'b0;
    bit         started  = 1'b0;

    function automatic int bump(input int c, input bit e, input bit clr);
        if (e && clr) return 1;
        if (clr) return 0;
        if (e) return (c < 255) ? c + 1 : 255;
        return c;
    endfunction

    // Model update on every clock edge from the inputs the DUTs also see.
    always @(posedge clk) begin
        bit cap, keep, popOk, want, ovfEvt, errEvt;
        int sz;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                mOvf[k]  = 1'b0;
                mErr[k]  = 0;
                mOvfC[k] = 0;
            end
            prevDone = 1'b0;
            started  = 1'b1;
        end else begin
            cap      = rxDone && !prevDone;
            prevDone = rxDone;
            errEvt   = cap && rxErr;
            for (int k = 0; k < 2; k++) begin
                keep   = (k == 1);
                sz     = mq[k].size();
                popOk  = rdEn && (sz > 0);
                want   = cap && (!rxErr || keep);
                ovfEvt = want && (sz == DEPTH) && !popOk;
                if (popOk) void'(mq[k].pop_front());
                if (want && !ovfEvt) mq[k].push_back(rxByte);
                if (ovfEvt) mOvf[k] = 1'b1;
                else if (clearFlags) mOvf[k] = 1'b0;
                mErr[k]  = bump(mErr[k], errEvt, clearFlags);
                mOvfC[k] = bump(mOvfC[k], ovfEvt, clearFlags);
            end
        end
    end

    // Compare both instances against the model away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                check("count", k, 32'(cnt[k]), mq[k].size());
                check("dataValid", k, 32'(dValid[k]), 32'(mq[k].size() > 0));
                check("full", k, 32'(full[k]), 32'(mq[k].size() == DEPTH));
                check("dataOut", k, 32'(dOut[k]), (mq[k].size() > 0) ? 32'(mq[k][0]) : 32'h0);
                check("overflow", k, 32'(ovf[k]), 32'(mOvf[k]));
                check("errCount", k, 32'(errC[k]), mErr[k]);
                check("ovfCount", k, 32'(ovfC[k]), mOvfC[k]);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic err, input int hold);
        rxByte = b;
        rxErr  = err;
        rxDone = 1'b1;
        step(hold);
        rxDone = 1'b0;
        rxErr  = 1'b0;
        step(1);
    endtask

    task automatic popOne();
        rdEn = 1'b1;
        step(1);
        rdEn = 1'b0;
    endtask

    task automatic pulseClear();
        clearFlags = 1'b1;
        step(1);
        clearFlags = 1'b0;
    endtask

    // Directed stimulus with hand-computed expectations at key points.
    initial begin
        reset      = 1'b1;
        rxDone     = 1'b0;
        rxErr      = 1'b0;
        rxByte     = 8'h00;
        rdEn       = 1'b0;
        clearFlags = 1'b0;
        step(2);
        reset = 1'b0;
        @(negedge clk);
        check("lit reset count", 0, 32'(cnt[0]), 32'd0);
        check("lit reset valid", 0, 32'(dValid[0]), 32'd0);
        check("lit reset dataOut", 0, 32'(dOut[0]), 32'h00);

        // Single byte then pop
        sendByte(8'hD6, 1'b0, 1);
        @(negedge clk);
        check("lit single count", 0, 32'(cnt[0]), 32'd1);
        check("lit single dataOut", 0, 32'(dOut[0]), 32'hD6);
        check("lit single valid", 0, 32'(dValid[0]), 32'd1);
        popOne();
        @(negedge clk);
        check("lit pop count", 0, 32'(cnt[0]), 32'd0);
        check("lit pop valid", 0, 32'(dValid[0]), 32'd0);

        // rxDone held high for five cycles
        sendByte(8'h3C, 1'b0, 5);
        @(negedge clk);
        check("lit held count", 0, 32'(cnt[0]), 32'd1);
        check("lit held dataOut", 0, 32'(dOut[0]), 32'h3C);
        popOne();

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) sendByte(8'(i), 1'b0, 1);
        @(negedge clk);
        check("lit fill full", 0, 32'(full[0]), 32'd1);
        check("lit fill count", 0, 32'(cnt[0]), 32'd16);
        sendByte(8'hAA, 1'b0, 1);
        @(negedge clk);
        check("lit ovf flag", 0, 32'(ovf[0]), 32'd1);
        check("lit ovf count", 0, 32'(ovfC[0]), 32'd1);
        check("lit ovf head", 0, 32'(dOut[0]), 32'h00);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("lit drain order", 0, 32'(dOut[0]), 32'(i));
            popOne();
        end
        pulseClear();
        @(negedge clk);
        check("lit clear ovf", 0, 32'(ovf[0]), 32'd0);
        check("lit clear ovfCount", 0, 32'(ovfC[0]), 32'd0);

        // Full with pop on the capture edge
        for (int i = 0; i < 16; i++) sendByte(8'(8'h10 + i), 1'b0, 1);
        rxByte = 8'h55;
        rxDone = 1'b1;
        rdEn   = 1'b1;
        step(1);
        rxDone = 1'b0;
        rdEn   = 1'b0;
        step(1);
        @(negedge clk);
        check("lit fullpop count", 0, 32'(cnt[0]), 32'd16);
        check("lit fullpop ovf", 0, 32'(ovf[0]), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("lit fullpop order", 0, 32'(dOut[0]), (i == 15) ? 32'h55 : 32'(8'h11 + i));
            popOne();
        end

        // Error bytes: dropped by dut0, kept by dut1
        sendByte(8'h77, 1'b1, 1);
        @(negedge clk);
        check("lit err drop count", 0, 32'(cnt[0]), 32'd0);
        check("lit err drop errCount", 0, 32'(errC[0]), 32'd1);
        check("lit err keep count", 1, 32'(cnt[1]), 32'd1);
        check("lit err keep errCount", 1, 32'(errC[1]), 32'd1);
        check("lit err keep dataOut", 1, 32'(dOut[1]), 32'h77);
        sendByte(8'h78, 1'b1, 1);
        // Error event coinciding with clearFlags
        rxByte     = 8'h79;
        rxErr      = 1'b1;
        rxDone     = 1'b1;
        clearFlags = 1'b1;
        step(1);
        rxDone     = 1'b0;
        rxErr      = 1'b0;
        clearFlags = 1'b0;
        step(1);
        @(negedge clk);
        check("lit clr+err errCount", 0, 32'(errC[0]), 32'd1);
        check("lit clr+err errCount", 1, 32'(errC[1]), 32'd1);
        check("lit clr+err keep count", 1, 32'(cnt[1]), 32'd3);
        repeat (3) popOne();

        // Empty with simultaneous write and read request
        rxByte = 8'h9A;
        rxDone = 1'b1;
        rdEn   = 1'b1;
        step(1);
        rxDone = 1'b0;
        rdEn   = 1'b0;
        step(1);
        @(negedge clk);
        check("lit empty wr+rd count", 0, 32'(cnt[0]), 32'd1);
        check("lit empty wr+rd dataOut", 0, 32'(dOut[0]), 32'h9A);
        popOne();

        // Streaming across the pointer wrap, three bytes kept in flight
        for (int i = 0; i < 40; i++) begin
            rxByte = 8'(i * 7 + 1);
            rxDone = 1'b1;
            rdEn   = (i >= 3);
            step(1);
            rxDone = 1'b0;
            rdEn   = 1'b0;
            step(1);
        end
        @(negedge clk);
        check("lit wrap count", 0, 32'(cnt[0]), 32'd3);
        check("lit wrap head", 0, 32'(dOut[0]), 32'(8'(37 * 7 + 1)));

        // Reset mid-stream
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        check("lit rst count", 0, 32'(cnt[0]), 32'd0);
        check("lit rst valid", 0, 32'(dValid[0]), 32'd0);
        check("lit rst errCount", 0, 32'(errC[0]), 32'd0);
        check("lit rst errCount", 1, 32'(errC[1]), 32'd0);
        check("lit rst dataOut", 1, 32'(dOut[1]), 32'h00);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
